// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode constants and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_GT   = 4'd12;
  localparam logic [3:0] OP_EQ   = 4'd13;
  localparam logic [3:0] OP_IDLE = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_rr_arb.sv
// Combinational requester selection for alu_arbiter.
// ALU_ARB_RR_EN selects round-robin (search starts at ptr+1); otherwise fixed priority, index 0 highest.
module alu_rr_arb #(
  parameter int  NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic found_s;

`ifdef ALU_ARB_RR_EN
  logic [IW-1:0] cand_s;

  // Rotating search beginning just after the previous winner.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IW'((int'(ptr) + 1 + k) % NREQ);
      if (!found_s && mask[cand_s]) begin
        grant[cand_s] = 1'b1;
        idx           = cand_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`else
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;

  // Lowest set index wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && mask[k]) begin
        grant[k] = 1'b1;
        idx      = IW'(k);
        found_s  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered 8-bit ALU among NREQ requesters, with a lock for chained (shift) operations.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int         NREQ    = 4,
  parameter logic [3:0] IDLE_OP = 4'b1111,
  localparam int        IW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_lock,
  output logic [3:0]        alu_op,
  output logic [7:0]        alu_in1,
  output logic [7:0]        alu_in2,
  input  logic [7:0]        alu_out,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IW-1:0]     resp_id,
  output logic [7:0]        resp_data,
  output logic              resp_carry,
  output logic              resp_ovf,
  output logic              busy
);

  state_t          state_r, state_nx_s;
  logic [NREQ-1:0] elig_s, grant_s, owner_mask_s, req_ready_s;
  logic [IW-1:0]   win_s, ptr_s, cur_id_r, owner_r;
  logic            accept_s, hs_s, lock_r, lock_pend_r, busy_r;
  logic [3:0]      alu_op_r;
  logic [7:0]      alu_in1_r, alu_in2_r;
  logic            resp_valid_r, resp_carry_r, resp_ovf_r;
  logic [IW-1:0]   resp_id_r;
  logic [7:0]      resp_data_r;

  // While locked only the owner may win, even if it has dropped its request.
  assign owner_mask_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
  assign elig_s       = lock_r ? (req_valid & owner_mask_s) : req_valid;

  alu_rr_arb #(.NREQ(NREQ)) u_arb (
    .mask  (elig_s),
    .ptr   (ptr_s),
    .grant (grant_s),
    .idx   (win_s)
  );

`ifdef ALU_ARB_RR_EN
  logic [IW-1:0] ptr_r;

  // Round-robin pointer remembers the last winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= IW'(NREQ - 1);
    end else if (accept_s) begin
      ptr_r <= win_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
  assign ptr_s = ptr_r;
`else
  assign ptr_s = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state, accept pulse and response handshake decode.
  always_comb begin
    state_nx_s  = state_r;
    accept_s    = 1'b0;
    hs_s        = 1'b0;
    req_ready_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (|elig_s) begin
          accept_s    = 1'b1;
          req_ready_s = grant_s;
          state_nx_s  = ST_ISSUE;
        end else begin
          state_nx_s  = ST_IDLE;
        end
      end
      ST_ISSUE: state_nx_s = ST_WAIT;
      ST_WAIT:  state_nx_s = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          hs_s       = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // ALU drive is loaded on the accept edge so it is valid throughout ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_r    <= IDLE_OP;
      alu_in1_r   <= 8'h00;
      alu_in2_r   <= 8'h00;
      cur_id_r    <= '0;
      lock_pend_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      if (accept_s) begin
        alu_op_r    <= req_op[{win_s, 2'b00} +: 4];
        alu_in1_r   <= req_a[{win_s, 3'b000} +: 8];
        alu_in2_r   <= req_b[{win_s, 3'b000} +: 8];
        cur_id_r    <= win_s;
        lock_pend_r <= req_lock[win_s];
      end else begin
        alu_op_r    <= IDLE_OP;
      end
    end
  end

  // Response capture in WAIT, hold until handshake; lock ownership changes on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_id_r    <= '0;
      resp_data_r  <= 8'h00;
      resp_carry_r <= 1'b0;
      resp_ovf_r   <= 1'b0;
      lock_r       <= 1'b0;
      owner_r      <= '0;
    end else begin
      if (state_r == ST_WAIT) begin
        resp_valid_r <= 1'b1;
        resp_id_r    <= cur_id_r;
        resp_data_r  <= alu_out;
        resp_carry_r <= alu_carry;
        resp_ovf_r   <= alu_ovf;
      end else if (hs_s) begin
        resp_valid_r <= 1'b0;
      end
      if (hs_s) begin
        lock_r  <= lock_pend_r;
        owner_r <= cur_id_r;
      end
    end
  end

  assign req_ready  = req_ready_s;
  assign alu_op     = alu_op_r;
  assign alu_in1    = alu_in1_r;
  assign alu_in2    = alu_in2_r;
  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_data  = resp_data_r;
  assign resp_carry = resp_carry_r;
  assign resp_ovf   = resp_ovf_r;
  assign busy       = busy_r;

endmodule
